// File: rtl/cnn_layer_scheduler.sv
// Command FIFO plus dispatch FSM for the accelerator's layer engines.
// Runs one command at a time: pop, start pulse, wait for done or fault.
module cnn_layer_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int CMD_DEPTH   = 8,
  parameter int CFG_WIDTH   = 32,
  parameter int TIMEOUT_W   = 16,
  parameter int ENG_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ENG_W-1:0]       cmd_engine,
  input  logic [CFG_WIDTH-1:0]   cmd_cfg,
  input  logic                   cmd_last,
  output logic [NUM_ENGINES-1:0] eng_start,
  output logic [CFG_WIDTH-1:0]   eng_cfg,
  input  logic [NUM_ENGINES-1:0] eng_done,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  output logic                   busy,
  output logic                   net_done,
  output logic [7:0]             layer_count,
  output logic                   err,
  output logic [1:0]             err_code,
  input  logic                   err_clr
);

  localparam int AW = $clog2(CMD_DEPTH);

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_TMO  = 2'b01;
  localparam logic [1:0] E_INV  = 2'b10;
  localparam logic [1:0] E_SPUR = 2'b11;

  typedef struct packed {
    logic [ENG_W-1:0]     eng;
    logic [CFG_WIDTH-1:0] cfg;
    logic                 last;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERROR
  } state_e;

  state_e state_q, state_d;

  cmd_t mem_q [CMD_DEPTH];
  cmd_t head;
  cmd_t cmd_in;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          full, empty;
  logic          push, pop, flush;

  logic [ENG_W-1:0]       cur_eng_q;
  logic [CFG_WIDTH-1:0]   cur_cfg_q;
  logic                   cur_last_q;
  logic [NUM_ENGINES-1:0] sel_oh;
  logic                   head_bad;

  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]           layer_q, layer_d;
  logic [1:0]           code_q, code_d;
  logic                 net_done_q, net_done_d;
  logic                 spur, hit, tmo;

  assign full   = (cnt_q == (AW+1)'(CMD_DEPTH));
  assign empty  = (cnt_q == '0);
  assign push   = cmd_valid && cmd_ready;
  assign head   = mem_q[rd_ptr_q];
  assign cmd_in = '{eng: cmd_engine, cfg: cmd_cfg, last: cmd_last};

  assign head_bad = (32'(head.eng) >= NUM_ENGINES);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      sel_oh[i] = (cur_eng_q == ENG_W'(i));
    end
  end

  // A done on any bit other than the one being waited for is a fault.
  assign spur = |(eng_done & ~sel_oh);
  assign hit  = |(eng_done & sel_oh);
  assign tmo  = (timeout_limit != '0) &&
                (wait_cnt_q == timeout_limit - TIMEOUT_W'(1));

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    wait_cnt_d = wait_cnt_q;
    layer_d    = layer_q;
    code_d     = code_q;
    net_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|eng_done) begin
          state_d = ERROR;
          code_d  = E_SPUR;
        end else if (!empty) begin
          pop = 1'b1;
          if (head_bad) begin
            state_d = ERROR;
            code_d  = E_INV;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        if (|eng_done) begin
          state_d = ERROR;
          code_d  = E_SPUR;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (spur) begin
          state_d = ERROR;
          code_d  = E_SPUR;
        end else if (hit) begin
          state_d    = IDLE;
          layer_d    = layer_q + 8'd1;
          net_done_d = cur_last_q;
        end else if (tmo) begin
          state_d = ERROR;
          code_d  = E_TMO;
        end else begin
          wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
        end
      end
      ERROR: begin
        if (err_clr) begin
          state_d = IDLE;
          code_d  = E_NONE;
          layer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush = (state_d == ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      layer_q    <= '0;
      code_q     <= E_NONE;
      net_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      layer_q    <= layer_d;
      code_q     <= code_d;
      net_done_q <= net_done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_eng_q  <= '0;
      cur_cfg_q  <= '0;
      cur_last_q <= 1'b0;
    end else if (pop) begin
      cur_eng_q  <= head.eng;
      cur_cfg_q  <= head.cfg;
      cur_last_q <= head.last;
    end
  end

  assign cmd_ready   = !rst && !full && (state_q != ERROR);
  assign eng_start   = (state_q == ISSUE) ? sel_oh : '0;
  assign eng_cfg     = cur_cfg_q;
  assign busy        = (state_q == ISSUE) || (state_q == WAIT) || !empty;
  assign net_done    = net_done_q;
  assign layer_count = layer_q;
  assign err         = (state_q == ERROR);
  assign err_code    = code_q;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed bench for cnn_layer_scheduler with a start scoreboard.
// Expected starts are queued at push time and matched at eng_start.
module tb_cnn_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_engine = '0;
  logic [31:0] cmd_cfg = '0;
  logic        cmd_last = 1'b0;
  logic [3:0]  eng_start;
  logic [31:0] eng_cfg;
  logic [3:0]  eng_done = '0;
  logic [15:0] timeout_limit = '0;
  logic        busy;
  logic        net_done;
  logic [7:0]  layer_count;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr = 1'b0;

  cnn_layer_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_engine    (cmd_engine),
    .cmd_cfg       (cmd_cfg),
    .cmd_last      (cmd_last),
    .eng_start     (eng_start),
    .eng_cfg       (eng_cfg),
    .eng_done      (eng_done),
    .timeout_limit (timeout_limit),
    .busy          (busy),
    .net_done      (net_done),
    .layer_count   (layer_count),
    .err           (err),
    .err_code      (err_code),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  eng;
    logic [31:0] cfg;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         n_starts = 0;
  int         served = 0;
  logic [3:0] last_start = '0;
  logic [7:0] lc_exp = '0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (eng_start != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_start", 64'(eng_start), 64'd0);
      end else begin
        exp_t       e;
        logic [3:0] oh;
        e  = sb.pop_front();
        oh = 4'b0001 << e.eng;
        check("start_onehot", 64'(eng_start), 64'(oh));
        check("start_cfg", 64'(eng_cfg), 64'(e.cfg));
      end
      n_starts++;
      last_start = eng_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] e, input logic [31:0] c,
                      input logic l, input bit exp_start);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      tick();
      t++;
    end
    check("push_ready", 64'(cmd_ready), 64'd1);
    if (cmd_ready) begin
      cmd_engine = e;
      cmd_cfg    = c;
      cmd_last   = l;
      cmd_valid  = 1'b1;
      if (exp_start) sb.push_back('{e, c});
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  // Waits for the next unserved start, then returns done (or a bad mask).
  task automatic serve(input int dly, input logic [3:0] bad);
    int t = 0;
    while (n_starts <= served && t < 50) begin
      tick();
      t++;
    end
    check("start_seen", 64'(n_starts > served), 64'd1);
    if (n_starts > served) begin
      served++;
      repeat (dly) tick();
      eng_done = (bad != '0) ? bad : last_start;
      tick();
      eng_done = '0;
      if (bad == '0) lc_exp++;
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    lc_exp = '0;
    served = n_starts;
    check("clr_err", 64'(err), 64'd0);
    check("clr_code", 64'(err_code), 64'd0);
    check("clr_layer", 64'(layer_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;

    #1 rst = 1'b1;
    #3;
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(eng_start), 64'd0);
    check("rst_cfg", 64'(eng_cfg), 64'd0);
    check("rst_err", 64'({err, err_code}), 64'd0);
    check("rst_layer", 64'(layer_count), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(cmd_ready), 64'd1);
    tick();

    // single command, done four cycles after start
    push(4'd1, 32'hA5A5_0001, 1'b1, 1'b1);
    check("s_k1_start", 64'(eng_start), 64'd0);
    tick();
    check("s_k2_start", 64'(eng_start), 64'h2);
    check("s_k2_cfg", 64'(eng_cfg), 64'hA5A5_0001);
    tick();
    check("s_k3_start", 64'(eng_start), 64'd0);
    check("s_busy", 64'(busy), 64'd1);
    serve(3, 4'b0000);
    check("s_net_done", 64'(net_done), 64'd1);
    check("s_layer", 64'(layer_count), 64'(lc_exp));
    check("s_cfg_held", 64'(eng_cfg), 64'hA5A5_0001);
    tick();
    check("s_net_done_1p", 64'(net_done), 64'd0);
    check("s_idle_busy", 64'(busy), 64'd0);

    // fill the FIFO while the first command stalls
    for (int i = 0; i < 9; i++) begin
      push(4'(i % 4), 32'h1000_0000 + 32'(i), (i == 8), 1'b1);
    end
    check("f_full_ready", 64'(cmd_ready), 64'd0);
    check("f_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 9; i++) begin
      serve(1, 4'b0000);
      check("f_net_done", 64'(net_done), 64'(i == 8));
    end
    check("f_layer", 64'(layer_count), 64'(lc_exp));
    check("f_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // timeout with two commands queued behind
    timeout_limit = 16'd5;
    push(4'd0, 32'hC0DE_0000, 1'b0, 1'b1);
    push(4'd1, 32'hC0DE_0001, 1'b0, 1'b0);
    push(4'd2, 32'hC0DE_0002, 1'b0, 1'b0);
    repeat (4) tick();
    check("t_wait4_err", 64'(err), 64'd0);
    tick();
    check("t_err", 64'(err), 64'd1);
    check("t_code", 64'(err_code), 64'h1);
    check("t_busy", 64'(busy), 64'd0);
    check("t_ready", 64'(cmd_ready), 64'd0);
    check("t_start", 64'(eng_start), 64'd0);
    tick();
    clear_err();
    snap = n_starts;
    repeat (4) tick();
    check("t_flushed", 64'(n_starts), 64'(snap));
    check("t_flush_busy", 64'(busy), 64'd0);
    push(4'd3, 32'hBEEF_0003, 1'b0, 1'b1);
    serve(0, 4'b0000);
    check("t_new_layer", 64'(layer_count), 64'(lc_exp));
    check("t_new_err", 64'(err), 64'd0);
    tick();

    // done in the last permitted WAIT cycle
    push(4'd2, 32'hBEEF_0002, 1'b0, 1'b1);
    tick();
    serve(4, 4'b0000);
    check("t4_err", 64'(err), 64'd0);
    check("t4_layer", 64'(layer_count), 64'(lc_exp));
    timeout_limit = 16'd0;
    tick();

    // invalid engine index
    snap = n_starts;
    push(4'd7, 32'hDEAD_0007, 1'b0, 1'b0);
    tick();
    check("i_err", 64'(err), 64'd1);
    check("i_code", 64'(err_code), 64'h2);
    check("i_nostart", 64'(n_starts), 64'(snap));
    tick();
    clear_err();

    // spurious done while waiting on engine 0
    push(4'd0, 32'h5000_0000, 1'b0, 1'b1);
    serve(1, 4'b0100);
    check("sp_err", 64'(err), 64'd1);
    check("sp_code", 64'(err_code), 64'h3);
    tick();
    clear_err();

    // spurious done in IDLE
    eng_done = 4'b0010;
    tick();
    eng_done = '0;
    check("spi_err", 64'(err), 64'd1);
    check("spi_code", 64'(err_code), 64'h3);
    tick();
    clear_err();

    // reset while waiting with three commands queued
    push(4'd1, 32'h7700_0001, 1'b1, 1'b1);
    push(4'd2, 32'h7700_0002, 1'b0, 1'b0);
    push(4'd3, 32'h7700_0003, 1'b0, 1'b0);
    push(4'd0, 32'h7700_0000, 1'b0, 1'b0);
    check("r_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("r_start", 64'(eng_start), 64'd0);
    check("r_cfg", 64'(eng_cfg), 64'd0);
    check("r_ready", 64'(cmd_ready), 64'd0);
    check("r_busy", 64'(busy), 64'd0);
    check("r_net_done", 64'(net_done), 64'd0);
    check("r_layer", 64'(layer_count), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    lc_exp = '0;
    served = n_starts;
    snap = n_starts;
    repeat (4) begin
      tick();
      check("r_post_net_done", 64'(net_done), 64'd0);
    end
    check("r_post_busy", 64'(busy), 64'd0);
    check("r_post_ready", 64'(cmd_ready), 64'd1);
    check("r_post_nostart", 64'(n_starts), 64'(snap));
    check("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
